// File: rtl/kl_pkg.sv
// Shared widths, request record and FSM encoding for the KL bus arbiter.
package kl_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int MASK_W = 8;
  localparam int SIZE_W = 3;
  localparam int ID_W   = 5;
  localparam int KL_REQ_W = ADDR_W + 1 + DATA_W + MASK_W + SIZE_W + ID_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } kl_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
    logic [SIZE_W-1:0] size;
    logic [ID_W-1:0]   srcid;
  } kl_req_t;
endpackage

// File: rtl/kl_rr_arb2.sv
// Two-way round-robin picker; ptr selects which requester wins a tie.
module kl_rr_arb2 (
  input  logic [1:0] eligible,
  input  logic       ptr,
  output logic [1:0] grant
);
  assign grant[0] = eligible[0] & (~ptr | ~eligible[1]);
  assign grant[1] = eligible[1] & ( ptr | ~eligible[0]);
endmodule

// File: rtl/kl_bus_arbiter.sv
// Shares one KL master port between I-cache (M0) and D-cache (M1); one request
// register, round-robin grant, combinational response steering by dstid.
//   state | meaning
//   IDLE  | no request on the bus; grant an eligible master this cycle
//   HOLD  | latched request presented on the bus until bus_req_ready
module kl_bus_arbiter
  import kl_pkg::*;
#(
  parameter logic [ID_W-1:0] SRCID_M0 = 5'd0,
  parameter logic [ID_W-1:0] SRCID_M1 = 5'd1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] m0_req_addr,
  input  logic              m0_req_wen,
  input  logic [DATA_W-1:0] m0_req_wdata,
  input  logic [MASK_W-1:0] m0_req_wmask,
  input  logic [SIZE_W-1:0] m0_req_size,
  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  output logic [DATA_W-1:0] m0_resp_rdata,
  output logic              m0_resp_ren,
  output logic [SIZE_W-1:0] m0_resp_size,
  output logic              m0_resp_valid,
  input  logic              m0_resp_ready,
  input  logic [ADDR_W-1:0] m1_req_addr,
  input  logic              m1_req_wen,
  input  logic [DATA_W-1:0] m1_req_wdata,
  input  logic [MASK_W-1:0] m1_req_wmask,
  input  logic [SIZE_W-1:0] m1_req_size,
  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  output logic [DATA_W-1:0] m1_resp_rdata,
  output logic              m1_resp_ren,
  output logic [SIZE_W-1:0] m1_resp_size,
  output logic              m1_resp_valid,
  input  logic              m1_resp_ready,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic              bus_req_wen,
  output logic [DATA_W-1:0] bus_req_wdata,
  output logic [MASK_W-1:0] bus_req_wmask,
  output logic [SIZE_W-1:0] bus_req_size,
  output logic [ID_W-1:0]   bus_req_srcid,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  input  logic [DATA_W-1:0] bus_resp_rdata,
  input  logic              bus_resp_ren,
  input  logic [SIZE_W-1:0] bus_resp_size,
  input  logic [ID_W-1:0]   bus_resp_dstid,
  input  logic              bus_resp_valid,
  output logic              bus_resp_ready,
  output logic [1:0]        pend,
  output logic              err_stray
);
  kl_state_e             state;
  logic                  rr_ptr;
  logic                  gnt_idx;
  logic [1:0]            eligible;
  logic [1:0]            grant;
  logic [1:0]            take;
  logic [1:0]            hit;
  logic [1:0]            resp_hs;
  logic                  stray;
  logic [KL_REQ_W-1:0]   req_q;
  kl_req_t               req_d;
  kl_req_t               req_view;

  assign eligible = {m1_req_valid & ~pend[1], m0_req_valid & ~pend[0]};

  kl_rr_arb2 u_arb (
    .eligible (eligible),
    .ptr      (rr_ptr),
    .grant    (grant)
  );

  assign take         = (state == ST_IDLE) ? grant : 2'b00;
  assign m0_req_ready = take[0];
  assign m1_req_ready = take[1];

  always_comb begin
    req_d = '0;
    if (grant[1]) begin
      req_d = '{addr: m1_req_addr, wen: m1_req_wen, wdata: m1_req_wdata,
                wmask: m1_req_wmask, size: m1_req_size, srcid: SRCID_M1};
    end else begin
      req_d = '{addr: m0_req_addr, wen: m0_req_wen, wdata: m0_req_wdata,
                wmask: m0_req_wmask, size: m0_req_size, srcid: SRCID_M0};
    end
  end

  assign req_view      = req_q;
  assign bus_req_addr  = req_view.addr;
  assign bus_req_wen   = req_view.wen;
  assign bus_req_wdata = req_view.wdata;
  assign bus_req_wmask = req_view.wmask;
  assign bus_req_size  = req_view.size;
  assign bus_req_srcid = req_view.srcid;

  // Only a master with a transaction in flight may accept a response.
  assign hit[0] = bus_resp_valid & (bus_resp_dstid == SRCID_M0) & pend[0];
  assign hit[1] = bus_resp_valid & (bus_resp_dstid == SRCID_M1) & pend[1];
  assign stray  = bus_resp_valid & ~(|hit);
  assign resp_hs = hit & {m1_resp_ready, m0_resp_ready};

  assign m0_resp_valid = hit[0];
  assign m1_resp_valid = hit[1];
  assign m0_resp_rdata = bus_resp_rdata;
  assign m1_resp_rdata = bus_resp_rdata;
  assign m0_resp_ren   = bus_resp_ren;
  assign m1_resp_ren   = bus_resp_ren;
  assign m0_resp_size  = bus_resp_size;
  assign m1_resp_size  = bus_resp_size;

  assign bus_resp_ready = hit[0] ? m0_resp_ready :
                          hit[1] ? m1_resp_ready : bus_resp_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      bus_req_valid <= 1'b0;
      req_q         <= '0;
      pend          <= 2'b00;
      rr_ptr        <= 1'b0;
      gnt_idx       <= 1'b0;
      err_stray     <= 1'b0;
    end else begin
      pend <= (pend & ~resp_hs) | take;
      if (stray) err_stray <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (|take) begin
            req_q         <= req_d;
            bus_req_valid <= 1'b1;
            gnt_idx       <= take[1];
            state         <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus_req_ready) begin
            bus_req_valid <= 1'b0;
            rr_ptr        <= ~gnt_idx;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
